mips_wb: RTL and testbench

MIPS_WB -- requirements
Module: mips_wb

---
 rtl/mips_wb.sv | 131 +++++++++++++
 tb/tb_mips_wb.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mips_wb.sv
// Write-back stage: merges ALU results and aligned load responses into one
// registered register-file write port, tracking up to two outstanding loads.
module mips_wb (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_D,
    input  logic        ld_issue,
    input  logic [4:0]  ld_rd,
    input  logic [2:0]  ld_op,
    input  logic [1:0]  ld_lo,
    output logic        ld_ready,
    input  logic        mem_valid,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic [4:0]  rd,
    output logic [3:0]  we,
    output logic [31:0] D,
    output logic [31:0] pend_mask,
    output logic        err
);

    // Handshakes: a load is pushed when ld_issue && ld_ready; a memory
    // response is consumed when mem_valid && mem_ready. Both take effect
    // at the rising clock edge.
    typedef struct packed {
        logic [4:0] rd;
        logic [2:0] op;
        logic [1:0] lo;
    } ld_entry_t;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LWL = 3'b010;
    localparam logic [2:0] OP_LW  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;
    localparam logic [2:0] OP_LWR = 3'b110;

    ld_entry_t   q0, q1;
    ld_entry_t   new_entry;
    logic [1:0]  count;
    logic        push, pop;
    logic [3:0]  ld_we;
    logic [31:0] ld_d;
    logic [31:0] shifted;
    logic [15:0] half_sel;

    assign ld_ready  = (count < 2'd2);
    assign mem_ready = (count != 2'd0) && !alu_valid;
    assign push      = ld_issue && ld_ready;
    assign pop       = mem_valid && mem_ready;
    assign new_entry = '{rd: ld_rd, op: ld_op, lo: ld_lo};

    // Queue head is always q0; q1 is only meaningful when count == 2.
    always_comb begin
        pend_mask = '0;
        if (count != 2'd0 && q0.rd != 5'd0) pend_mask[q0.rd] = 1'b1;
        if (count == 2'd2 && q1.rd != 5'd0) pend_mask[q1.rd] = 1'b1;
    end

    always_comb begin
        ld_we    = 4'b0000;
        ld_d     = '0;
        shifted  = mem_data >> {q0.lo, 3'b000};
        half_sel = q0.lo[1] ? mem_data[31:16] : mem_data[15:0];
        case (q0.op)
            OP_LB:  begin ld_we = 4'b1111; ld_d = {{24{shifted[7]}}, shifted[7:0]}; end
            OP_LBU: begin ld_we = 4'b1111; ld_d = {24'd0, shifted[7:0]}; end
            OP_LH:  begin ld_we = 4'b1111; ld_d = {{16{half_sel[15]}}, half_sel}; end
            OP_LHU: begin ld_we = 4'b1111; ld_d = {16'd0, half_sel}; end
            OP_LW:  begin ld_we = 4'b1111; ld_d = mem_data; end
            OP_LWL: begin
                ld_we = 4'b1111 << (2'd3 - q0.lo);
                ld_d  = mem_data << {2'd3 - q0.lo, 3'b000};
            end
            OP_LWR: begin
                ld_we = 4'b1111 >> q0.lo;
                ld_d  = shifted;
            end
            default: begin ld_we = 4'b0000; ld_d = '0; end
        endcase
        if (q0.rd == 5'd0) ld_we = 4'b0000;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            q0    <= '0;
            q1    <= '0;
            count <= 2'd0;
            rd    <= 5'd0;
            we    <= 4'b0000;
            D     <= '0;
            err   <= 1'b0;
        end else begin
            err <= err | (ld_issue && !ld_ready) | (mem_valid && count == 2'd0);

            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) q0 <= new_entry;
                    else               q1 <= new_entry;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    q0    <= q1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    q0 <= (count == 2'd1) ? new_entry : q1;
                    q1 <= new_entry;
                end
                default: ;
            endcase

            // ALU results win the port; a pending load response simply waits.
            if (alu_valid) begin
                rd <= alu_rd;
                we <= (alu_rd != 5'd0) ? 4'b1111 : 4'b0000;
                D  <= alu_D;
            end else if (pop) begin
                rd <= q0.rd;
                we <= ld_we;
                D  <= ld_d;
            end else begin
                we <= 4'b0000;
            end
        end
    end

endmodule

// File: tb/tb_mips_wb.sv
// Bench for mips_wb: directed stimulus, expected writes queued at acceptance
// and checked by an independent monitor whenever the write port fires.
module tb_mips_wb;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_D;
    logic        ld_issue;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_op;
    logic [1:0]  ld_lo;
    logic        ld_ready;
    logic        mem_valid;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic [4:0]  rd;
    logic [3:0]  we;
    logic [31:0] D;
    logic [31:0] pend_mask;
    logic        err;

    int tests_run = 0;
    int tests_failed = 0;
    logic [40:0] exp_q[$];

    mips_wb dut (
        .clock(clock), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_D(alu_D),
        .ld_issue(ld_issue), .ld_rd(ld_rd), .ld_op(ld_op), .ld_lo(ld_lo),
        .ld_ready(ld_ready),
        .mem_valid(mem_valid), .mem_data(mem_data), .mem_ready(mem_ready),
        .rd(rd), .we(we), .D(D), .pend_mask(pend_mask), .err(err)
    );

    always #5 clock = ~clock;

    // Monitor: every non-zero write enable must match the oldest expectation.
    always @(negedge clock) begin
        if (we != 4'b0000) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL write_unexpected: got rd=%0d we=%b D=%h, required no write", rd, we, D);
            end else begin
                logic [40:0] e;
                e = exp_q.pop_front();
                if ({rd, we, D} !== e) begin
                    tests_failed++;
                    $display("FAIL write: got rd=%0d we=%b D=%h, required rd=%0d we=%b D=%h",
                             rd, we, D, e[40:36], e[35:32], e[31:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        alu_valid = 0; alu_rd = 0; alu_D = 0;
        ld_issue = 0; ld_rd = 0; ld_op = 0; ld_lo = 0;
        mem_valid = 0; mem_data = 0;
    endtask

    task automatic issue(input logic [4:0] r, input logic [2:0] op, input logic [1:0] lo);
        ld_issue = 1; ld_rd = r; ld_op = op; ld_lo = lo;
    endtask

    task automatic expect_wr(input logic [4:0] r, input logic [3:0] w, input logic [31:0] d);
        exp_q.push_back({r, w, d});
    endtask

    initial begin
        idle();
        reset_n = 0;
        tick(); tick();
        check("rst_rd", {27'd0, rd}, 32'd0);
        check("rst_we", {28'd0, we}, 32'd0);
        check("rst_D", D, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        check("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_pend_mask", pend_mask, 32'd0);
        reset_n = 1;
        tick();

        // LW r5, lo=0
        issue(5'd5, 3'b011, 2'd0); tick(); idle();
        check("lw_pend", pend_mask, 32'h0000_0020);
        mem_valid = 1; mem_data = 32'h80FF1234; #1;
        check("lw_mem_ready", {31'd0, mem_ready}, 32'd1);
        check("lw_pend_before_pop", pend_mask, 32'h0000_0020);
        expect_wr(5'd5, 4'b1111, 32'h80FF1234);
        tick(); idle(); #1;
        check("lw_pend_after_pop", pend_mask, 32'd0);

        // LB r3 lo=3, LBU r4 lo=3
        issue(5'd3, 3'b000, 2'd3); tick();
        issue(5'd4, 3'b100, 2'd3); tick(); idle(); #1;
        check("lb_ld_ready_full", {31'd0, ld_ready}, 32'd0);
        check("lb_pend", pend_mask, 32'h0000_0018);
        mem_valid = 1; mem_data = 32'h80FF1234;
        expect_wr(5'd3, 4'b1111, 32'hFFFFFF80); tick();
        expect_wr(5'd4, 4'b1111, 32'h00000080); tick(); idle();

        // Push and pop in one cycle keeps order
        issue(5'd10, 3'b011, 2'd0); tick();
        issue(5'd11, 3'b101, 2'd2); mem_valid = 1; mem_data = 32'h12345678;
        expect_wr(5'd10, 4'b1111, 32'h12345678); tick(); idle(); #1;
        check("pp_pend", pend_mask, 32'h0000_0800);
        check("pp_ld_ready", {31'd0, ld_ready}, 32'd1);
        mem_valid = 1; mem_data = 32'h9ABCDEF0;
        expect_wr(5'd11, 4'b1111, 32'h00009ABC); tick(); idle();

        // LH upper half, a[0] ignored
        issue(5'd12, 3'b001, 2'd3); tick(); idle();
        mem_valid = 1; mem_data = 32'h7FFE0000;
        expect_wr(5'd12, 4'b1111, 32'h00007FFE); tick(); idle();

        // LWL / LWR r7 lo=1
        issue(5'd7, 3'b010, 2'd1); tick();
        issue(5'd7, 3'b110, 2'd1); tick(); idle();
        mem_valid = 1; mem_data = 32'hAABBCCDD;
        expect_wr(5'd7, 4'b1100, 32'hCCDD0000); tick();
        expect_wr(5'd7, 4'b0111, 32'h00AABBCC); tick(); idle();

        // ALU priority over pending LH r2
        issue(5'd2, 3'b001, 2'd0); tick(); idle();
        alu_valid = 1; alu_rd = 5'd9; alu_D = 32'h11;
        mem_valid = 1; mem_data = 32'h12348001; #1;
        check("alu_mem_ready", {31'd0, mem_ready}, 32'd0);
        expect_wr(5'd9, 4'b1111, 32'h00000011); tick();
        check("alu_pend_hold", pend_mask, 32'h0000_0004);
        alu_valid = 0; #1;
        check("alu_drop_mem_ready", {31'd0, mem_ready}, 32'd1);
        expect_wr(5'd2, 4'b1111, 32'hFFFF8001); tick(); idle();

        // Reserved op retires silently; loads/ALU to r0 write nothing
        issue(5'd13, 3'b111, 2'd0); tick(); idle();
        mem_valid = 1; mem_data = 32'hDEADBEEF; tick(); idle(); #1;
        check("rsv_pend", pend_mask, 32'd0);
        issue(5'd0, 3'b011, 2'd0); tick(); idle(); #1;
        check("r0_pend", pend_mask, 32'd0);
        check("r0_mem_ready", {31'd0, mem_ready}, 32'd1);
        mem_valid = 1; mem_data = 32'hCAFEF00D; tick(); idle(); #1;
        check("r0_we", {28'd0, we}, 32'd0);
        alu_valid = 1; alu_rd = 5'd0; alu_D = 32'h55; tick(); idle(); #1;
        check("alu_r0_we", {28'd0, we}, 32'd0);
        check("err_clean", {31'd0, err}, 32'd0);

        // Overflow issue
        issue(5'd20, 3'b011, 2'd0); tick();
        issue(5'd21, 3'b011, 2'd0); tick(); #1;
        check("ovf_ld_ready", {31'd0, ld_ready}, 32'd0);
        issue(5'd22, 3'b011, 2'd0); tick(); idle(); #1;
        check("ovf_err", {31'd0, err}, 32'd1);
        check("ovf_pend", pend_mask, 32'h0030_0000);

        // Reset with two pending
        reset_n = 0; tick(); #1;
        check("rst2_pend", pend_mask, 32'd0);
        check("rst2_ld_ready", {31'd0, ld_ready}, 32'd1);
        check("rst2_err", {31'd0, err}, 32'd0);
        reset_n = 1;

        // Response with empty queue
        mem_valid = 1; mem_data = 32'h1; tick(); idle(); #1;
        check("empty_err", {31'd0, err}, 32'd1);
        tick(); tick();
        check("err_sticky", {31'd0, err}, 32'd1);
        check("exp_q_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
